// File: rtl/rom_load_packer.sv
// Packs a stream of flash bytes into little-endian 16-bit words and writes them
// to SDRAM through a small word FIFO, stepping the byte address by 2 per word.
module rom_load_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] base_addr,
  input  logic [23:0] byte_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_wr,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_data,
  input  logic        mem_busy,
  output logic        active,
  output logic        done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t          state, next_state;
  logic [23:0]     remaining;
  logic            phase;
  logic [7:0]      low_byte;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]  fifo_count;
  logic            cooldown;

  logic            start_ok, fifo_full, fifo_empty;
  logic            xfer, pad_push, push, accept;
  logic [15:0]     push_word;

  assign start_ok   = start && (state == IDLE || state == DONE);
  assign fifo_full  = fifo_count == (PTR_W+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_count == '0;

  assign byte_ready = (state == PACK) && (remaining != '0) && !fifo_full;
  assign xfer       = byte_valid && byte_ready;
  // An odd-length job leaves a low byte waiting; it goes out padded with 8'hFF.
  assign pad_push   = (state == PACK) && (remaining == '0) && phase && !fifo_full;
  assign push       = (xfer && phase) || pad_push;
  assign push_word  = pad_push ? {8'hFF, low_byte} : {byte_data, low_byte};

  assign mem_wr   = !fifo_empty && !cooldown;
  assign accept   = mem_wr && !mem_busy;
  assign mem_data = mem_wr ? fifo_mem[rd_ptr] : '0;
  assign active   = (state == PACK) || (state == FLUSH);
  assign done     = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_ok) next_state = (byte_count == '0) ? DONE : PACK;
      PACK:       if (remaining == '0 && !phase) next_state = FLUSH;
      FLUSH:      if (fifo_empty || (fifo_count == (PTR_W+1)'(1) && accept))
                    next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining  <= '0;
      phase      <= 1'b0;
      low_byte   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cooldown   <= 1'b0;
      mem_addr   <= '0;
    end else if (start_ok) begin
      remaining  <= byte_count;
      phase      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cooldown   <= 1'b0;
      mem_addr   <= base_addr;
    end else begin
      if (xfer) begin
        remaining <= remaining - 24'd1;
        phase     <= !phase;
        if (!phase) low_byte <= byte_data;
      end
      if (pad_push) phase <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (accept) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_addr <= mem_addr + 25'd2;
      end
      // Forces a one-cycle gap in mem_wr after every accepted write.
      cooldown <= accept;
      case ({push, accept})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the empty count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_rom_load_packer.sv
// Directed bench for rom_load_packer: byte source queue, write scoreboard,
// one task per scenario with hand-computed expected writes.
module tb_rom_load_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [24:0] base_addr = '0;
  logic [23:0] byte_count = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        mem_wr;
  logic [24:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_busy = 1'b0;
  logic        active;
  logic        done;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [7:0] src [$];
  int         src_idx = 0;
  wr_t        wrs [$];

  rom_load_packer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_busy(mem_busy), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  // Drives the byte source, logs transfers/acceptances due at the next edge,
  // then advances to 1 time unit after that edge.
  task automatic cycle();
    byte_valid = (src_idx < src.size());
    byte_data  = byte_valid ? src[src_idx] : 8'h00;
    #1;
    if (byte_valid && byte_ready) src_idx++;
    if (mem_wr && !mem_busy) wrs.push_back('{mem_addr, mem_data});
    @(posedge clk);
    #1;
  endtask

  task automatic new_job(input logic [24:0] base, input logic [23:0] cnt);
    start = 1'b1; base_addr = base; byte_count = cnt;
    cycle();
    start = 1'b0;
  endtask

  task automatic clear_bench();
    src.delete(); src_idx = 0; wrs.delete();
  endtask

  task automatic run_until_done(input string name);
    int n = 0;
    while (!done && n < 200) begin cycle(); n++; end
    total++;
    if (done !== 1'b1) $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, n);
    else passed++;
  endtask

  task automatic check_wr(input string name, input int i, input logic [24:0] a, input logic [15:0] d);
    total++;
    if (i >= wrs.size())
      $display("FAIL %s_wr%0d: missing write, want (%h,%h)", name, i, a, d);
    else if (wrs[i].addr !== a || wrs[i].data !== d)
      $display("FAIL %s_wr%0d: got (%h,%h) want (%h,%h)", name, i, wrs[i].addr, wrs[i].data, a, d);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({mem_wr, byte_ready, active, done, mem_addr, mem_data} !== '0)
      $display("FAIL reset_outputs: wr=%b rdy=%b act=%b done=%b addr=%h data=%h want all 0",
               mem_wr, byte_ready, active, done, mem_addr, mem_data);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    src = '{8'h5A, 8'hA5};
    for (int i = 0; i < 4; i++) cycle();
    total++;
    if ({mem_wr, byte_ready, active, done, mem_addr, mem_data} !== '0 || src_idx !== 0)
      $display("FAIL idle_quiet: wr=%b rdy=%b act=%b done=%b addr=%h taken=%0d want all 0",
               mem_wr, byte_ready, active, done, mem_addr, src_idx);
    else passed++;
    clear_bench();
  endtask

  task automatic test_even_job();
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    new_job(25'h0, 24'd4);
    total++;
    if (active !== 1'b1) $display("FAIL even_active: got %b want 1", active);
    else passed++;
    cycle();
    total++;
    if (mem_wr !== 1'b0) $display("FAIL even_early_wr: got %b want 0", mem_wr);
    else passed++;
    cycle();
    total++;
    if (mem_wr !== 1'b1 || mem_addr !== 25'h0 || mem_data !== 16'h2211)
      $display("FAIL even_latency: wr=%b addr=%h data=%h want 1,0000000,2211", mem_wr, mem_addr, mem_data);
    else passed++;
    run_until_done("even");
    for (int i = 0; i < 3; i++) cycle();
    total++;
    if (wrs.size() !== 2 || done !== 1'b1 || active !== 1'b0)
      $display("FAIL even_count: writes=%0d done=%b active=%b want 2,1,0", wrs.size(), done, active);
    else passed++;
    check_wr("even", 0, 25'h0, 16'h2211);
    check_wr("even", 1, 25'h2, 16'h4433);
    clear_bench();
  endtask

  task automatic test_odd_job();
    src = '{8'hAA, 8'hBB, 8'hCC};
    new_job(25'h100, 24'd3);
    run_until_done("odd");
    total++;
    if (wrs.size() !== 2) $display("FAIL odd_count: got %0d writes want 2", wrs.size());
    else passed++;
    check_wr("odd", 0, 25'h100, 16'hBBAA);
    check_wr("odd", 1, 25'h102, 16'hFFCC);
    clear_bench();
  endtask

  task automatic test_busy_backpressure();
    logic seen = 1'b0;
    logic stable = 1'b1;
    for (int i = 0; i < 12; i++) src.push_back(8'(i + 1));
    mem_busy = 1'b1;
    new_job(25'h40, 24'd12);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mem_wr) seen = 1'b1;
      if (seen && (mem_wr !== 1'b1 || mem_addr !== 25'h40 || mem_data !== 16'h0201)) stable = 1'b0;
    end
    total++;
    if (src_idx !== 8 || byte_ready !== 1'b0)
      $display("FAIL busy_fill: bytes taken=%0d ready=%b want 8,0", src_idx, byte_ready);
    else passed++;
    total++;
    if (!seen || !stable || wrs.size() !== 0)
      $display("FAIL busy_hold: seen=%b stable=%b accepted=%0d want 1,1,0", seen, stable, wrs.size());
    else passed++;
    mem_busy = 1'b0;
    run_until_done("busy");
    total++;
    if (wrs.size() !== 6) $display("FAIL busy_count: got %0d writes want 6", wrs.size());
    else passed++;
    for (int i = 0; i < 6; i++)
      check_wr("busy", i, 25'h40 + 25'(2 * i), {8'(2 * i + 2), 8'(2 * i + 1)});
    clear_bench();
  endtask

  task automatic test_addr_wrap();
    src = '{8'h55, 8'h66, 8'h77, 8'h88};
    new_job(25'h1FFFFFE, 24'd4);
    run_until_done("wrap");
    check_wr("wrap", 0, 25'h1FFFFFE, 16'h6655);
    check_wr("wrap", 1, 25'h0000000, 16'h8877);
  endtask

  task automatic test_zero_and_ignored_start();
    clear_bench();
    new_job(25'h10, 24'd0);
    total++;
    if (done !== 1'b1 || active !== 1'b0 || mem_wr !== 1'b0)
      $display("FAIL zero_done: done=%b active=%b wr=%b want 1,0,0", done, active, mem_wr);
    else passed++;
    for (int i = 0; i < 4; i++) cycle();
    total++;
    if (wrs.size() !== 0 || done !== 1'b1)
      $display("FAIL zero_nowrite: writes=%0d done=%b want 0,1", wrs.size(), done);
    else passed++;
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    new_job(25'h200, 24'd4);
    total++;
    if (done !== 1'b0 || active !== 1'b1)
      $display("FAIL restart_state: done=%b active=%b want 0,1", done, active);
    else passed++;
    new_job(25'h300, 24'd2);
    run_until_done("ignore");
    total++;
    if (wrs.size() !== 2) $display("FAIL ignore_count: got %0d writes want 2", wrs.size());
    else passed++;
    check_wr("ignore", 0, 25'h200, 16'h0201);
    check_wr("ignore", 1, 25'h202, 16'h0403);
    clear_bench();
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    mem_busy = 1'b1;
    new_job(25'h80, 24'd8);
    while (!mem_wr && n < 20) begin cycle(); n++; end
    total++;
    if (mem_wr !== 1'b1) $display("FAIL mid_setup: wr=%b want 1", mem_wr);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({mem_wr, byte_ready, active, done, mem_addr, mem_data} !== '0)
      $display("FAIL async_reset: wr=%b rdy=%b act=%b done=%b addr=%h data=%h want all 0",
               mem_wr, byte_ready, active, done, mem_addr, mem_data);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0; mem_busy = 1'b0;
    clear_bench();
    for (int i = 0; i < 5; i++) cycle();
    total++;
    if (wrs.size() !== 0 || active !== 1'b0 || done !== 1'b0 || mem_addr !== 25'h0)
      $display("FAIL post_reset_idle: writes=%0d act=%b done=%b addr=%h want 0,0,0,0",
               wrs.size(), active, done, mem_addr);
    else passed++;
    src = '{8'h9A, 8'hBC};
    new_job(25'h0, 24'd2);
    run_until_done("after_reset");
    total++;
    if (wrs.size() !== 1) $display("FAIL after_reset_count: got %0d writes want 1", wrs.size());
    else passed++;
    check_wr("after_reset", 0, 25'h0, 16'hBC9A);
    clear_bench();
  endtask

  initial begin
    test_reset();
    test_even_job();
    test_odd_job();
    test_busy_backpressure();
    test_addr_wrap();
    test_zero_and_ignored_start();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
